// File: rtl/cpu_pkg.sv
// Shared definitions for the ten-bit CPU pipeline: widths, reset PC, the fetch
// FSM state type and the {pc, instr} packet handed from fetch to decode.
package cpu_pkg;

    localparam int WORD_W = 10;
    localparam logic [WORD_W-1:0] RESET_PC = '0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_packet_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO of fetch packets. Slot 0 is always the head, so the
// decode-facing outputs come straight from a register.
module fetch_skid_fifo
    import cpu_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  fetch_packet_t push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_packet_t head,
    output logic [1:0]    count
);

    fetch_packet_t slot0_q, slot0_d;
    fetch_packet_t slot1_q, slot1_d;
    logic [1:0]    count_q, count_d;
    logic          do_pop;

    // Flush wins; a simultaneous push and pop keeps the occupancy constant.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        do_pop  = pop && (count_q != 2'd0);
        if (flush) begin
            count_d = 2'd0;
        end else if (push && do_pop) begin
            if (count_q == 2'd1) begin
                slot0_d = push_data;
            end else begin
                slot0_d = slot1_q;
                slot1_d = push_data;
            end
        end else if (push) begin
            if (count_q == 2'd0) begin
                slot0_d = push_data;
            end else begin
                slot1_d = push_data;
            end
            count_d = count_q + 2'd1;
        end else if (do_pop) begin
            slot0_d = slot1_q;
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign head  = slot0_q;
    assign count = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues addresses to the synchronous instruction
// memory and hands returned words to decode through a skid buffer.
module instruction_fetch #(
    parameter int                WORD_W   = 10,
    parameter logic [WORD_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              fetch_enable,
    input  logic              branch_valid,
    input  logic [WORD_W-1:0] branch_target,
    output logic [WORD_W-1:0] im_address,
    input  logic [WORD_W-1:0] im_instruction,
    output logic              if_valid,
    input  logic              dec_ready,
    output logic [WORD_W-1:0] if_instruction,
    output logic [WORD_W-1:0] if_pc
);

    import cpu_pkg::*;

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;

    logic              pop;
    logic              issue;
    logic [2:0]        occupancy;
    logic [1:0]        count;
    fetch_packet_t     head;
    fetch_packet_t     push_pkt;

    // A new issue is allowed only if the word it returns is guaranteed a slot.
    assign pop       = if_valid & dec_ready;
    assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = (state_q == RUN) && (occupancy < 3'd2) && !branch_valid;

    always_comb begin
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        state_d       = state_q;
        if (branch_valid) begin
            pc_d = branch_target;
        end else if (issue) begin
            pc_d          = pc_q + WORD_W'(1);
            inflight_pc_d = pc_q;
        end
        case (state_q)
            IDLE:    if (fetch_enable)  state_d = RUN;
            RUN:     if (!fetch_enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign push_pkt = '{pc: inflight_pc_q, instr: im_instruction};

    // A redirect discards the returning word and any buffered ones.
    fetch_skid_fifo u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (inflight_q & ~branch_valid),
        .push_data (push_pkt),
        .pop       (pop & ~branch_valid),
        .flush     (branch_valid),
        .head      (head),
        .count     (count)
    );

    assign im_address     = pc_q;
    assign if_valid       = (count != 2'd0);
    assign if_pc          = head.pc;
    assign if_instruction = head.instr;

endmodule
